router_sched_clocked: RTL and testbench

//  Clocked switch scheduler and datapath for one 3-port fat-tree router node (ports C1, C2, P).
//  - Decodes each incoming 9-bit flit and routes it to one output.
//  - Arbitrates round-robin between the two inputs that compete for each output.
//  - Registers every output.

---
 rtl/router_sched_clocked.sv | 139 +++++++++++++
 tb/tb_router_sched_clocked.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_sched_clocked.sv
// Clocked scheduler and registered datapath for one 3-port fat-tree router node (C1, C2, P).
// Optional parity checking on the C1/C2 outputs is enabled by defining ROUTER_PARITY_CHECK_EN.
module router_sched_clocked #(
    parameter logic [3:0] ADDRESS = 4'd0,
    parameter logic [3:0] MASK    = 4'd0,
    parameter int         WIDTH   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c1_in_valid,
    input  logic [WIDTH-1:0] c1_in_data,
    output logic             c1_in_ready,
    input  logic             c2_in_valid,
    input  logic [WIDTH-1:0] c2_in_data,
    output logic             c2_in_ready,
    input  logic             p_in_valid,
    input  logic [WIDTH-1:0] p_in_data,
    output logic             p_in_ready,
    output logic             c1_out_valid,
    output logic [WIDTH-1:0] c1_out_data,
    input  logic             c1_out_ready,
    output logic             c2_out_valid,
    output logic [WIDTH-1:0] c2_out_data,
    input  logic             c2_out_ready,
    output logic             p_out_valid,
    output logic [WIDTH-1:0] p_out_data,
    input  logic             p_out_ready,
    output logic             c1_out_err,
    output logic             c2_out_err,
    output logic [7:0]       err_cnt
);
    localparam int C1 = 0;
    localparam int C2 = 1;
    localparam int P  = 2;
    // Downward routing bit for P flits sits just below the masked address bits.
    localparam int P_SEL_BIT = 8 - $countones(MASK);

    logic c1_to_c2, c2_to_c1, p_to_c2;
    logic [2:0] req0, req1, gnt0, gnt1, load, xfer, last_pick, out_valid, out_ready;
    logic [WIDTH-1:0] in0_data [3];
    logic [WIDTH-1:0] in1_data [3];
    logic [WIDTH-1:0] nxt_data [3];
    logic [WIDTH-1:0] out_data [3];

    assign out_ready = {p_out_ready, c2_out_ready, c1_out_ready};

    always_comb begin
        c1_to_c2 = (c1_in_data[8:5] & MASK) == ADDRESS;
        c2_to_c1 = (c2_in_data[8:5] & MASK) == ADDRESS;
        p_to_c2  = (MASK == 4'b1111) ? 1'b1 : p_in_data[P_SEL_BIT];
    end

    // Candidate pair (In0, In1) for each output.
    always_comb begin
        req0[C1] = c2_in_valid & c2_to_c1;
        req1[C1] = p_in_valid & ~p_to_c2;
        req0[C2] = c1_in_valid & c1_to_c2;
        req1[C2] = p_in_valid & p_to_c2;
        req0[P]  = c1_in_valid & ~c1_to_c2;
        req1[P]  = c2_in_valid & ~c2_to_c1;
        in0_data[C1] = c2_in_data;
        in1_data[C1] = p_in_data;
        in0_data[C2] = c1_in_data;
        in1_data[C2] = p_in_data;
        in0_data[P]  = c1_in_data;
        in1_data[P]  = c2_in_data;
    end

    always_comb begin
        for (int o = 0; o < 3; o++) begin
            gnt1[o]     = req1[o] & (~req0[o] | ~last_pick[o]);
            gnt0[o]     = req0[o] & ~gnt1[o];
            load[o]     = ~out_valid[o] | out_ready[o];
            xfer[o]     = (gnt0[o] | gnt1[o]) & load[o];
            nxt_data[o] = gnt1[o] ? in1_data[o] : in0_data[o];
        end
    end

    assign c1_in_ready = rst_n & (c1_to_c2 ? (gnt0[C2] & load[C2]) : (gnt0[P] & load[P]));
    assign c2_in_ready = rst_n & (c2_to_c1 ? (gnt0[C1] & load[C1]) : (gnt1[P] & load[P]));
    assign p_in_ready  = rst_n & (p_to_c2  ? (gnt1[C2] & load[C2]) : (gnt1[C1] & load[C1]));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            last_pick <= '0;
            // NOTE: output data registers are few and visible on ports, so they are reset explicitly.
            for (int o = 0; o < 3; o++) out_data[o] <= '0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (xfer[o]) begin
                    out_data[o]  <= nxt_data[o];
                    out_valid[o] <= 1'b1;
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
                if (xfer[o] & req0[o] & req1[o]) last_pick[o] <= ~last_pick[o];
            end
        end
    end

    assign c1_out_valid = out_valid[C1];
    assign c2_out_valid = out_valid[C2];
    assign p_out_valid  = out_valid[P];
    assign c1_out_data  = out_data[C1];
    assign c2_out_data  = out_data[C2];
    assign p_out_data   = out_data[P];

`ifdef ROUTER_PARITY_CHECK_EN
    logic [1:0] err_new, err_q;
    logic [8:0] cnt_sum;
    logic [7:0] cnt_q;

    always_comb begin
        for (int o = 0; o < 2; o++) err_new[o] = (^nxt_data[o][8:1]) != nxt_data[o][0];
        cnt_sum = {1'b0, cnt_q} + {8'd0, xfer[C1] & err_new[C1]} + {8'd0, xfer[C2] & err_new[C2]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int o = 0; o < 2; o++) if (xfer[o]) err_q[o] <= err_new[o];
            cnt_q <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
    end

    assign c1_out_err = err_q[C1];
    assign c2_out_err = err_q[C2];
    assign err_cnt    = cnt_q;
`else
    assign c1_out_err = 1'b0;
    assign c2_out_err = 1'b0;
    assign err_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_router_sched_clocked.sv
// Randomized scoreboard bench for router_sched_clocked (ADDRESS=4'b0100, MASK=4'b1100).
// Compile with ROUTER_PARITY_CHECK_EN defined to expect parity flags and error counting.
`timescale 1ns/1ps
module tb_router_sched_clocked;
    localparam logic [3:0] ADDRESS = 4'b0100;
    localparam logic [3:0] MASK    = 4'b1100;
    localparam int         WIDTH   = 9;
`ifdef ROUTER_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed { logic [8:0] data; logic err; } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] in_valid = '0;
    logic [8:0] in_data [3];
    logic [2:0] out_ready = '0;

    wire       c1_in_ready, c2_in_ready, p_in_ready;
    wire       c1_out_valid, c2_out_valid, p_out_valid;
    wire [8:0] c1_out_data, c2_out_data, p_out_data;
    wire       c1_out_err, c2_out_err;
    wire [7:0] err_cnt;
    wire [2:0] in_ready  = {p_in_ready, c2_in_ready, c1_in_ready};
    wire [2:0] out_valid = {p_out_valid, c2_out_valid, c1_out_valid};
    wire [1:0] out_err   = {c2_out_err, c1_out_err};
    logic [8:0] out_data [3];
    assign out_data[0] = c1_out_data;
    assign out_data[1] = c2_out_data;
    assign out_data[2] = p_out_data;

    exp_t sb [3][$];
    int   last_win [3];
    int   pout_src [$];
    int   model_cnt;
    logic [2:0] acc;
    int   n_vec;
    int   n_fail;

    router_sched_clocked #(.ADDRESS(ADDRESS), .MASK(MASK), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .c1_in_valid(in_valid[0]), .c1_in_data(in_data[0]), .c1_in_ready(c1_in_ready),
        .c2_in_valid(in_valid[1]), .c2_in_data(in_data[1]), .c2_in_ready(c2_in_ready),
        .p_in_valid(in_valid[2]),  .p_in_data(in_data[2]),  .p_in_ready(p_in_ready),
        .c1_out_valid(c1_out_valid), .c1_out_data(c1_out_data), .c1_out_ready(out_ready[0]),
        .c2_out_valid(c2_out_valid), .c2_out_data(c2_out_data), .c2_out_ready(out_ready[1]),
        .p_out_valid(p_out_valid),   .p_out_data(p_out_data),   .p_out_ready(out_ready[2]),
        .c1_out_err(c1_out_err), .c2_out_err(c2_out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference routing: 0=C1, 1=C2, 2=P for both sources and destinations.
    function automatic int dest_of(input int src, input logic [8:0] d);
        int   k;
        logic match;
        k     = 8 - $countones(MASK);
        match = ((d[8:5] & MASK) == ADDRESS);
        case (src)
            0:       return match ? 1 : 2;
            1:       return match ? 0 : 2;
            default: return (MASK == 4'b1111) ? 1 : (d[k] ? 1 : 0);
        endcase
    endfunction

    function automatic int cand(input int o, input int which);
        case (o)
            0:       return (which == 0) ? 1 : 2;
            1:       return (which == 0) ? 0 : 2;
            default: return (which == 0) ? 0 : 1;
        endcase
    endfunction

    function automatic logic bad_parity(input logic [8:0] d);
        return (^d[8:1]) != d[0];
    endfunction

    task automatic push(input int o, input logic [8:0] d);
        logic e;
        e = PAR_EN && (o < 2) && bad_parity(d);
        sb[o].push_back('{data: d, err: e});
        if (e && model_cnt < 255) model_cnt++;
    endtask

    // Monitor: compares whatever each output presents against its scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int o = 0; o < 3; o++) begin
                check($sformatf("out%0d_valid", o), 32'(out_valid[o]), 32'(sb[o].size() != 0));
                if (out_valid[o] && sb[o].size() != 0) begin
                    check($sformatf("out%0d_data", o), 32'(out_data[o]), 32'(sb[o][0].data));
                    if (o < 2) check($sformatf("out%0d_err", o), 32'(out_err[o]), 32'(sb[o][0].err));
                    if (out_ready[o]) void'(sb[o].pop_front());
                end
            end
            check("err_cnt", 32'(err_cnt), 32'(model_cnt));
        end
    end

    // Accept detection and arbitration expectations for the coming edge.
    task automatic eval_cycle();
        acc = '0;
        for (int o = 0; o < 3; o++) begin
            int   s0, s1;
            logic r0, r1, a0, a1;
            s0 = cand(o, 0);
            s1 = cand(o, 1);
            r0 = in_valid[s0] && (dest_of(s0, in_data[s0]) == o);
            r1 = in_valid[s1] && (dest_of(s1, in_data[s1]) == o);
            a0 = r0 && in_ready[s0];
            a1 = r1 && in_ready[s1];
            check($sformatf("out%0d_accepts", o), 32'(int'(a0) + int'(a1)),
                  32'((r0 || r1) && sb[o].size() == 0));
            if (r0 && r1 && (a0 ^ a1)) begin
                check($sformatf("out%0d_winner", o), a1 ? 32'd1 : 32'd0, (last_win[o] == 1) ? 32'd0 : 32'd1);
                last_win[o] = a1 ? 1 : 0;
            end
            if (a0) begin push(o, in_data[s0]); acc[s0] = 1'b1; if (o == 2) pout_src.push_back(0); end
            if (a1) begin push(o, in_data[s1]); acc[s1] = 1'b1; if (o == 2) pout_src.push_back(1); end
        end
    endtask

    task automatic step();
        @(negedge clk); #2;
        if (rst_n) eval_cycle(); else acc = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) if (acc[i]) in_valid[i] = 1'b0;
    endtask

    task automatic offer(input int src, input logic [8:0] d);
        in_valid[src] = 1'b1;
        in_data[src]  = d;
    endtask

    task automatic send_one(input int src, input logic [8:0] d, input int dst);
        int n;
        n = 0;
        offer(src, d);
        do begin step(); n++; end while (!acc[src] && n < 20);
        check($sformatf("send_%03h_accepted", d), 32'(acc[src]), 32'd1);
        check($sformatf("send_%03h_out_valid", d), 32'(out_valid[dst]), 32'd1);
        check($sformatf("send_%03h_out_data", d), 32'(out_data[dst]), 32'(d));
        in_valid = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = '1;
        while (in_valid != 0 && n < 20) begin step(); n++; end
        check("drain_inputs", 32'(in_valid), 32'd0);
        repeat (2) step();
    endtask

    task automatic reset_model();
        for (int o = 0; o < 3; o++) begin
            sb[o].delete();
            last_win[o] = -1;
        end
        model_cnt = 0;
    endtask

    initial begin
        int exp_order [4];
        int cnt;
        int n;
        logic [8:0] held;
        exp_order = '{1, 0, 1, 0};
        n_vec = 0;
        n_fail = 0;
        acc = '0;
        reset_model();

        // Reset with every input offering a flit.
        in_data[0] = 9'h081; in_data[1] = 9'h000; in_data[2] = 9'h041;
        in_valid = '1;
        out_ready = '1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        for (int o = 0; o < 3; o++) check($sformatf("rst_out%0d_data", o), 32'(out_data[o]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        // C2->P alone, C1 and P contend for C2 and P (In1) wins first.
        check("first_accepts_after_release", 32'(acc), 32'b110);
        drain();

        send_one(0, 9'h081, 1);
        send_one(0, 9'h181, 2);
        send_one(2, 9'h000, 0);
        send_one(2, 9'h041, 1);
        repeat (2) step();

        // C1 and C2 both streaming into Pout.
        pout_src.delete();
        for (int i = 0; i < 8; i++) begin
            if (!in_valid[0]) offer(0, {4'b1000, 5'($urandom)});
            if (!in_valid[1]) offer(1, {4'b0000, 5'($urandom)});
            step();
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("pout_order_%0d", i), (i < pout_src.size()) ? 32'(pout_src[i]) : 32'd9,
                  32'(exp_order[i]));
        n = 0;
        while (in_valid[0] && n < 4) begin
            if (!in_valid[1]) offer(1, {4'b0000, 5'($urandom)});
            step();
            n++;
        end
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (!in_valid[1]) offer(1, {4'b0000, 5'($urandom)});
            step();
            if (acc[1]) cnt++;
        end
        check("c2_alone_rate", 32'(cnt), 32'd6);
        drain();

        // Backpressure on Pout.
        out_ready[2] = 1'b0;
        offer(0, {4'b1000, 5'($urandom)});
        offer(1, {4'b0000, 5'($urandom)});
        step();
        held = p_out_data;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_c1c2_accepts", 32'(acc[1:0]), 32'd0);
        end
        check("stall_data_stable", 32'(p_out_data), 32'(held));
        out_ready[2] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (!in_valid[0]) offer(0, {4'b1000, 5'($urandom)});
            if (!in_valid[1]) offer(1, {4'b0000, 5'($urandom)});
            step();
            if (acc[0] || acc[1]) cnt++;
        end
        check("resume_rate", 32'(cnt), 32'd6);
        drain();

        // Parity errors into C2 and counter saturation.
        send_one(0, 9'h080, 1);
        check("err_flag_080", 32'(c2_out_err), 32'(PAR_EN));
        check("err_cnt_first", 32'(err_cnt), PAR_EN ? 32'd1 : 32'd0);
        cnt = 0;
        n = 0;
        while (cnt < 260 && n < 400) begin
            if (!in_valid[0]) offer(0, 9'h080);
            step();
            if (acc[0]) cnt++;
            n++;
        end
        drain();
        check("err_cnt_saturated", 32'(err_cnt), PAR_EN ? 32'hFF : 32'd0);

        // Random traffic with a reset in the middle.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!in_valid[i] && $urandom_range(0, 9) < 6) offer(i, 9'($urandom));
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            if (c == 700) begin
                rst_n = 1'b0;
                reset_model();
                #1;
                check("midrst_in_ready", 32'(in_ready), 32'd0);
                check("midrst_out_valid", 32'(out_valid), 32'd0);
                check("midrst_err_cnt", 32'(err_cnt), 32'd0);
                step();
                step();
                rst_n = 1'b1;
            end
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
